// File: rtl/airlock_cycle_timer.sv
// Airlock chamber sequencer: pressurize/evacuate countdown with abort, done/err pulses.
// Optional countdown pause input enabled by macro AIRLOCK_HOLD_EN.
module airlock_cycle_timer #(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned PRESS_CYCLES = 8,
  parameter int unsigned EVAC_CYCLES  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start_press,
  input  logic             start_evac,
  input  logic             abort,
`ifdef AIRLOCK_HOLD_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic             pressurized,
  output logic             evacuated,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, PRESS, EVAC, DONE} state_t;

  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_CYCLES - 1);

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             aborted_q;
  logic             press_q;
  logic             evac_q;
  logic [CNT_W-1:0] rem_q;
  logic             hold_act;

`ifdef AIRLOCK_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  // Sequencer: pulses default low each cycle, flags and counter held unless updated.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      press_q   <= 1'b0;
      evac_q    <= 1'b0;
      rem_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_press && start_evac) begin
            err_q <= 1'b1;
          end else if (start_press) begin
            if (press_q) begin
              err_q <= 1'b1;
            end else begin
              state_q <= PRESS;
              busy_q  <= 1'b1;
              rem_q   <= PRESS_LOAD;
              press_q <= 1'b0;
              evac_q  <= 1'b0;
            end
          end else if (start_evac) begin
            if (evac_q) begin
              err_q <= 1'b1;
            end else begin
              state_q <= EVAC;
              busy_q  <= 1'b1;
              rem_q   <= EVAC_LOAD;
              press_q <= 1'b0;
              evac_q  <= 1'b0;
            end
          end
        end
        PRESS, EVAC: begin
          // abort outranks both expiry and hold
          if (abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            rem_q     <= '0;
            aborted_q <= 1'b1;
          end else if (!hold_act) begin
            if (rem_q == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (state_q == PRESS) press_q <= 1'b1;
              else                  evac_q  <= 1'b1;
            end else begin
              rem_q <= rem_q - 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign aborted     = aborted_q;
  assign pressurized = press_q;
  assign evacuated   = evac_q;
  assign remaining   = rem_q;

endmodule

// File: tb/tb_airlock_cycle_timer.sv
// Directed self-checking bench for airlock_cycle_timer (PRESS_CYCLES=8, EVAC_CYCLES=5).
module tb_airlock_cycle_timer;

  localparam int unsigned CNT_W = 4;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             start_press;
  logic             start_evac;
  logic             abort;
  logic             hold;
  logic             busy, done, err, aborted, pressurized, evacuated;
  logic [CNT_W-1:0] remaining;

  int n_cmp = 0;
  int n_err = 0;

  airlock_cycle_timer #(.CNT_W(CNT_W), .PRESS_CYCLES(8), .EVAC_CYCLES(5)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .start_press (start_press),
    .start_evac  (start_evac),
    .abort       (abort),
`ifdef AIRLOCK_HOLD_EN
    .hold        (hold),
`endif
    .busy        (busy),
    .done        (done),
    .err         (err),
    .aborted     (aborted),
    .pressurized (pressurized),
    .evacuated   (evacuated),
    .remaining   (remaining)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Compares {busy,done,err,aborted,pressurized,evacuated,remaining}.
  task automatic chk(input string tag, input logic b, input logic d, input logic e,
                     input logic a, input logic p, input logic v, input logic [CNT_W-1:0] r);
    logic [CNT_W+5:0] obs;
    logic [CNT_W+5:0] exp;
    obs = {busy, done, err, aborted, pressurized, evacuated, remaining};
    exp = {b, d, e, a, p, v, r};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed b%0b d%0b e%0b a%0b p%0b v%0b r%0d expected b%0b d%0b e%0b a%0b p%0b v%0b r%0d",
             tag, obs[CNT_W+5], obs[CNT_W+4], obs[CNT_W+3], obs[CNT_W+2], obs[CNT_W+1], obs[CNT_W],
             obs[CNT_W-1:0], b, d, e, a, p, v, r);
    end
  endtask

  initial begin
    Reset = 1'b0; start_press = 1'b0; start_evac = 1'b0; abort = 1'b0; hold = 1'b0;
    step(); step();
    chk("reset", 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    step();
    chk("idle", 0, 0, 0, 0, 0, 0, 0);

    // Pressurize run, N=8
    start_press = 1'b1; step(); start_press = 1'b0;
    chk("press_start", 1, 0, 0, 0, 0, 0, 7);
    for (int i = 6; i >= 0; i--) begin
      step();
      chk($sformatf("press_rem%0d", i), 1, 0, 0, 0, 0, 0, 4'(i));
    end
    step();
    chk("press_done", 0, 1, 0, 0, 1, 0, 0);
    step();
    chk("press_idle", 0, 0, 0, 0, 1, 0, 0);

    // Illegal requests
    start_press = 1'b1; start_evac = 1'b1; step(); start_press = 1'b0; start_evac = 1'b0;
    chk("both_err", 0, 0, 1, 0, 1, 0, 0);
    step();
    chk("both_err_clear", 0, 0, 0, 0, 1, 0, 0);
    start_press = 1'b1; step(); start_press = 1'b0;
    chk("press_held_err", 0, 0, 1, 0, 1, 0, 0);
    step();
    chk("press_held_clear", 0, 0, 0, 0, 1, 0, 0);

    // Evacuate run, N=5, pressurized clears at start edge
    start_evac = 1'b1; step(); start_evac = 1'b0;
    chk("evac_start", 1, 0, 0, 0, 0, 0, 4);
    for (int i = 3; i >= 0; i--) begin
      step();
      chk($sformatf("evac_rem%0d", i), 1, 0, 0, 0, 0, 0, 4'(i));
    end
    step();
    chk("evac_done", 0, 1, 0, 0, 0, 1, 0);
    step();
    chk("evac_idle", 0, 0, 0, 0, 0, 1, 0);
    start_evac = 1'b1; step(); start_evac = 1'b0;
    chk("evac_held_err", 0, 0, 1, 0, 0, 1, 0);

    // Abort at remaining==0 of a press run
    start_press = 1'b1; step(); start_press = 1'b0;
    chk("abrt_start", 1, 0, 0, 0, 0, 0, 7);
    for (int i = 0; i < 7; i++) step();
    chk("abrt_rem0", 1, 0, 0, 0, 0, 0, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abrt_pulse", 0, 0, 0, 1, 0, 0, 0);
    step();
    chk("abrt_no_done", 0, 0, 0, 0, 0, 0, 0);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abrt_idle_ignored", 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-evacuate at remaining==3
    start_evac = 1'b1; step(); start_evac = 1'b0;
    step();
    chk("rst_rem3", 1, 0, 0, 0, 0, 0, 3);
    Reset = 1'b0; step(); Reset = 1'b1;
    chk("rst_mid_run", 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rst_after", 0, 0, 0, 0, 0, 0, 0);

    // Restart; a start while busy is ignored without err
    start_evac = 1'b1; step(); start_evac = 1'b0;
    chk("restart", 1, 0, 0, 0, 0, 0, 4);
    start_press = 1'b1; step(); start_press = 1'b0;
    chk("busy_start_ignored", 1, 0, 0, 0, 0, 0, 3);
    for (int i = 2; i >= 0; i--) step();
    chk("restart_rem0", 1, 0, 0, 0, 0, 0, 0);
    step();
    chk("restart_done", 0, 1, 0, 0, 0, 1, 0);
    step();

`ifdef AIRLOCK_HOLD_EN
    // Hold for 4 cycles at remaining==5 delays done by 4
    start_press = 1'b1; step(); start_press = 1'b0;
    step(); step();
    chk("hold_rem5", 1, 0, 0, 0, 0, 0, 5);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold_%0d", i), 1, 0, 0, 0, 0, 0, 5);
    end
    hold = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      step();
      chk($sformatf("hold_rem%0d", i), 1, 0, 0, 0, 0, 0, 4'(i));
    end
    step();
    chk("hold_done", 0, 1, 0, 0, 1, 0, 0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
